upc_scroll_detector: RTL and testbench

Parametrised, clocked successor to the combinational UPC item detector. It synchronises and debounces the 4-bit M/U/P/C switch code, latches a stable item code, and drives registered `sale`/`stolen` flags. It scrolls the item's 8-character name across `NUM_DIGITS` seven-segment digits, and holds a sticky theft alarm until it is acknowledged. It sits between the board switches/keys and the HEX display bank.

---
 rtl/upc_pkg.sv | 78 +++++++
 rtl/upc_scroll_detector_debounce.sv | 51 +++++
 rtl/upc_scroll_detector.sv | 127 ++++++++++++
 tb/tb_upc_scroll_detector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/upc_pkg.sv
// Shared item codes, character set, 7-segment encodings and name table for the UPC scroll detector.
// Segment vectors are active-low, bit 0 = segment a, bit 6 = segment g.
package upc_pkg;

  localparam int MSG_LEN = 8;

  localparam logic [3:0] GLASSES   = 4'd0;
  localparam logic [3:0] TOP_HAT   = 4'd1;
  localparam logic [3:0] WATER     = 4'd3;
  localparam logic [3:0] PISTOL    = 4'd4;
  localparam logic [3:0] LAUGH_GAS = 4'd5;
  localparam logic [3:0] HUSKY_TEE = 4'd6;

  typedef enum logic {ST_IDLE, ST_SHOW} state_e;

  typedef enum logic [4:0] {
    CH_BLANK, CH_DASH, CH_A, CH_E, CH_G, CH_H, CH_I, CH_K, CH_L,
    CH_O, CH_P, CH_R, CH_S, CH_T, CH_U, CH_W, CH_Y
  } char_e;

  function automatic logic [6:0] char_seg(input char_e c);
    case (c)
      CH_A:    char_seg = 7'h08;
      CH_E:    char_seg = 7'h06;
      CH_G:    char_seg = 7'h42;
      CH_H:    char_seg = 7'h09;
      CH_I:    char_seg = 7'h79;
      CH_K:    char_seg = 7'h0A;
      CH_L:    char_seg = 7'h47;
      CH_O:    char_seg = 7'h40;
      CH_P:    char_seg = 7'h0C;
      CH_R:    char_seg = 7'h2F;
      CH_S:    char_seg = 7'h12;
      CH_T:    char_seg = 7'h07;
      CH_U:    char_seg = 7'h41;
      CH_W:    char_seg = 7'h55;
      CH_Y:    char_seg = 7'h11;
      CH_DASH: char_seg = 7'h3F;
      default: char_seg = 7'h7F;
    endcase
  endfunction

  // Character 0 of each name sits in the most significant slot.
  function automatic logic [MSG_LEN*5-1:0] item_name(input logic [3:0] code);
    case (code)
      GLASSES:   item_name = {CH_G, CH_L, CH_A, CH_S, CH_S, CH_E, CH_S, CH_BLANK};
      TOP_HAT:   item_name = {CH_T, CH_O, CH_P, CH_BLANK, CH_H, CH_A, CH_T, CH_BLANK};
      WATER:     item_name = {CH_W, CH_A, CH_T, CH_E, CH_R, CH_BLANK, CH_BLANK, CH_BLANK};
      PISTOL:    item_name = {CH_P, CH_I, CH_S, CH_T, CH_O, CH_L, CH_BLANK, CH_BLANK};
      LAUGH_GAS: item_name = {CH_L, CH_A, CH_U, CH_G, CH_H, CH_G, CH_A, CH_S};
      HUSKY_TEE: item_name = {CH_H, CH_U, CH_S, CH_K, CH_Y, CH_T, CH_E, CH_E};
      default:   item_name = {8{CH_DASH}};
    endcase
  endfunction

  function automatic char_e name_char(input logic [3:0] code, input logic [2:0] idx);
    logic [MSG_LEN*5-1:0] nm;
    nm = item_name(code);
    return char_e'(nm[5*(MSG_LEN-1-int'(idx)) +: 5]);
  endfunction

  function automatic logic code_valid(input logic [3:0] code);
    case (code)
      GLASSES, TOP_HAT, WATER, PISTOL, LAUGH_GAS, HUSKY_TEE: code_valid = 1'b1;
      default: code_valid = 1'b0;
    endcase
  endfunction

  // code = {M, U, P, C}
  function automatic logic code_sale(input logic [3:0] code);
    return (code[2] & code[0]) | code[1];
  endfunction

  function automatic logic code_stolen(input logic [3:0] code);
    return ~code[1] & ~code[3] & (code[2] | ~code[0]);
  endfunction

endpackage

// File: rtl/upc_scroll_detector_debounce.sv
// Two-flop synchroniser plus stability counter; accept_o pulses for one cycle with code_o valid.
// A value reaches accept STABLE_CYCLES+2 edges after it is first sampled.
module upc_debounce #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] code_o,
  output logic             accept_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [2:0]       fill_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             same;

  // Until the synchroniser has filled after reset, its contents count as a fresh change.
  assign same     = fill_q[2] && (sync2_q == prev_q);
  assign accept_o = same && (cnt_q == CW'(STABLE_CYCLES - 1));
  assign code_o   = sync2_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/upc_scroll_detector.sv
// Debounced UPC item detector with registered sale/stolen/valid, sticky alarm and scrolling name display.
// Outputs update STABLE_CYCLES+3 edges after a SW change; define UPC_SCROLL_EN to enable scrolling.
module upc_scroll_detector
  import upc_pkg::*;
#(
  parameter int NUM_DIGITS    = 5,
  parameter int STABLE_CYCLES = 1000,
  parameter int TICK_DIV      = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              SW,
  input  logic                    ack,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    sale,
  output logic                    stolen,
  output logic                    valid,
  output logic                    alarm
);

  logic [3:0] acc_code;
  logic       acc_vld;

  upc_debounce #(.WIDTH(4), .STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .din_i    (SW),
    .code_o   (acc_code),
    .accept_o (acc_vld)
  );

  state_e                  state_q, state_d;
  logic [3:0]              code_q, code_d;
  logic                    sale_q, sale_d, stolen_q, stolen_d;
  logic                    valid_q, valid_d, alarm_q, alarm_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [2:0]              pos_d;
  logic                    load;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    load     = 1'b0;
    if (acc_vld && (state_q == ST_IDLE || acc_code != code_q)) begin
      load    = 1'b1;
      state_d = ST_SHOW;
      code_d  = acc_code;
    end
    sale_d   = (state_d == ST_SHOW) && code_sale(code_d);
    stolen_d = (state_d == ST_SHOW) && code_stolen(code_d);
    valid_d  = (state_d == ST_SHOW) && code_valid(code_d);
    alarm_d  = alarm_q;
    if (alarm_q && ack && !stolen_q) alarm_d = 1'b0;
    if (load && stolen_d) alarm_d = 1'b1;
  end

`ifdef UPC_SCROLL_EN
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    pos_q;

  always_comb begin
    tick_d = tick_q;
    pos_d  = pos_q;
    if (load || !valid_d) begin
      tick_d = '0;
      pos_d  = '0;
    end else if (tick_q == TW'(TICK_DIV - 1)) begin
      tick_d = '0;
      pos_d  = pos_q + 3'd1;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      pos_q  <= '0;
    end else begin
      tick_q <= tick_d;
      pos_q  <= pos_d;
    end
  end
`else
  logic unused_tick_div;
  assign unused_tick_div = (TICK_DIV > 1);
  assign pos_d = '0;
`endif

  // Digit d shows ring character pos + NUM_DIGITS-1-d so the name reads left to right.
  always_comb begin
    hex_d = '1;
    if (state_d == ST_SHOW) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        hex_d[7*d +: 7] = char_seg(name_char(code_d, pos_d + 3'(NUM_DIGITS - 1 - d)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      sale_q   <= 1'b0;
      stolen_q <= 1'b0;
      valid_q  <= 1'b0;
      alarm_q  <= 1'b0;
      hex_q    <= '1;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      sale_q   <= sale_d;
      stolen_q <= stolen_d;
      valid_q  <= valid_d;
      alarm_q  <= alarm_d;
      hex_q    <= hex_d;
    end
  end

  assign hex    = hex_q;
  assign sale   = sale_q;
  assign stolen = stolen_q;
  assign valid  = valid_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_upc_scroll_detector.sv
// Directed bench for upc_scroll_detector with STABLE_CYCLES=4, TICK_DIV=8, five digits.
// Expected segment words come from a local character table and ring model.
module tb_upc_scroll_detector;

  localparam int ND = 5;
  localparam int SC = 4;
  localparam int TD = 8;
`ifdef UPC_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, ack;
  logic [3:0]    SW;
  logic [7*ND-1:0] hex;
  logic          sale, stolen, valid, alarm;

  always #5 clk = ~clk;

  upc_scroll_detector #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TICK_DIV(TD)) dut (
    .clk    (clk),
    .reset  (reset),
    .SW     (SW),
    .ack    (ack),
    .hex    (hex),
    .sale   (sale),
    .stolen (stolen),
    .valid  (valid),
    .alarm  (alarm)
  );

  localparam logic [6:0] S_A = 7'h08, S_E = 7'h06, S_G = 7'h42, S_H = 7'h09, S_I = 7'h79;
  localparam logic [6:0] S_K = 7'h0A, S_L = 7'h47, S_O = 7'h40, S_P = 7'h0C, S_R = 7'h2F;
  localparam logic [6:0] S_S = 7'h12, S_T = 7'h07, S_U = 7'h41, S_W = 7'h55, S_Y = 7'h11;
  localparam logic [6:0] S_B = 7'h7F, S_D = 7'h3F;

  localparam logic [55:0] N_GLASSES = {S_G, S_L, S_A, S_S, S_S, S_E, S_S, S_B};
  localparam logic [55:0] N_TOPHAT  = {S_T, S_O, S_P, S_B, S_H, S_A, S_T, S_B};
  localparam logic [55:0] N_WATER   = {S_W, S_A, S_T, S_E, S_R, S_B, S_B, S_B};
  localparam logic [55:0] N_PISTOL  = {S_P, S_I, S_S, S_T, S_O, S_L, S_B, S_B};
  localparam logic [55:0] N_LAUGH   = {S_L, S_A, S_U, S_G, S_H, S_G, S_A, S_S};
  localparam logic [55:0] N_HUSKY   = {S_H, S_U, S_S, S_K, S_Y, S_T, S_E, S_E};
  localparam logic [55:0] N_DASH    = {8{S_D}};

  typedef struct {
    logic [3:0]  sw;
    logic        sale, stolen, valid, alarm_ld, alarm_ack;
    logic [55:0] name;
  } vec_t;

  vec_t tv [9];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ld_cyc = 0;
  logic [55:0] cur_name;
  logic [3:0]  cur_flags;
  logic [7*ND-1:0] blank;

  function automatic logic [7*ND-1:0] ring(input logic [55:0] nm, input int pos);
    logic [7*ND-1:0] h;
    int idx;
    h = '1;
    for (int d = 0; d < ND; d++) begin
      idx = (pos + ND - 1 - d) % 8;
      h[7*d +: 7] = nm[55-7*idx -: 7];
    end
    return h;
  endfunction

  function automatic int exp_pos(input int since);
    return SCROLL ? (since / TD) % 8 : 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    blank = '1;
    //            sw       sale  stol  vld   al_ld al_ack name
    tv[0] = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, N_DASH};
    tv[1] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, N_TOPHAT};
    tv[2] = '{4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, N_WATER};
    tv[3] = '{4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, N_PISTOL};
    tv[4] = '{4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, N_LAUGH};
    tv[5] = '{4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, N_HUSKY};
    tv[6] = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N_DASH};
    tv[7] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N_DASH};
    tv[8] = '{4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N_DASH};

    reset = 1'b1; SW = 4'd0; ack = 1'b0;
    repeat (3) step();
    check("reset_hex", hex, blank);
    check("reset_flags", {sale, stolen, valid, alarm}, 4'b0000);

    // First code after reset: blank through edge 6, GLASSES on edge 7.
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("idle_hex", hex, blank);
      check("idle_flags", {sale, stolen, valid, alarm}, 4'b0000);
    end
    step();
    ld_cyc = cyc;
    check("glasses_hex", hex, ring(N_GLASSES, 0));
    check("glasses_flags", {sale, stolen, valid, alarm}, 4'b0111);
    cur_name = N_GLASSES;
    cur_flags = 4'b0111;

    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ack_while_stolen", alarm, 1'b1);
    end
    ack = 1'b0;

    for (int i = 0; i < 9; i++) begin
      SW = tv[i].sw;
      repeat (6) step();
      check("early_hex", hex, ring(cur_name, exp_pos(cyc - ld_cyc)));
      check("early_flags", {sale, stolen, valid, alarm}, cur_flags);
      step();
      ld_cyc = cyc;
      check("load_hex", hex, ring(tv[i].name, 0));
      check("load_flags", {sale, stolen, valid, alarm},
            {tv[i].sale, tv[i].stolen, tv[i].valid, tv[i].alarm_ld});
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("ack_alarm", alarm, tv[i].alarm_ack);
      cur_name = tv[i].name;
      cur_flags = {tv[i].sale, tv[i].stolen, tv[i].valid, tv[i].alarm_ack};
    end

    // Short glitch 1 -> 3 -> 1 must not disturb TOP_HAT or its scroll position.
    SW = 4'd1;
    repeat (7) step();
    ld_cyc = cyc;
    check("tophat_hex", hex, ring(N_TOPHAT, 0));
    for (int k = 1; k <= 18; k++) begin
      if (k == 1) SW = 4'd3;
      if (k == 3) SW = 4'd1;
      step();
      check("glitch_hex", hex, ring(N_TOPHAT, exp_pos(cyc - ld_cyc)));
      check("glitch_flags", {sale, stolen, valid, alarm}, 4'b0010);
    end

    // Scroll through the full ring including the 7 -> 0 wrap.
    SW = 4'd6;
    repeat (7) step();
    ld_cyc = cyc;
    check("husky_hex", hex, ring(N_HUSKY, 0));
    for (int k = 1; k <= 80; k++) begin
      step();
      check("scroll_hex", hex, ring(N_HUSKY, exp_pos(cyc - ld_cyc)));
    end

    // Alarm held under ack while stolen, then reset mid-scroll.
    SW = 4'd4;
    repeat (7) step();
    ld_cyc = cyc;
    check("pistol_flags", {sale, stolen, valid, alarm}, 4'b0111);
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("pistol_ack_hold", alarm, 1'b1);
    end
    ack = 1'b0;
    repeat (6) step();
    check("pistol_scrolled", hex, ring(N_PISTOL, exp_pos(cyc - ld_cyc)));
    reset = 1'b1;
    step();
    check("midrun_reset_hex", hex, blank);
    check("midrun_reset_flags", {sale, stolen, valid, alarm}, 4'b0000);
    reset = 1'b0;
    repeat (6) step();
    check("post_reset_idle", hex, blank);
    step();
    check("post_reset_load", hex, ring(N_PISTOL, 0));
    check("post_reset_flags", {sale, stolen, valid, alarm}, 4'b0111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
